// File: rtl/gate_bist_controller.sv
`default_nettype none
// ============================================================================
// gate_bist_controller: LFSR-driven stimulus and MISR response compaction for
// a combinational GateModel netlist. GATEBIST_SETTLE_EN adds per-vector hold.
// Revision: 1.0
// ============================================================================
module gate_bist_controller #(
  parameter int              IN_W     = 21,
  parameter int              OUT_W    = 10,
  parameter int              PATTERNS = 1024,
  parameter logic [IN_W-1:0] SEED     = 'h1,
  parameter logic [15:0]     GOLDEN   = 16'h0000,
  parameter int              SETTLE   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [IN_W-1:0]   stim,
  input  logic [OUT_W-1:0]  resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    APPLY     = 3'd1,
    SETTLE_ST = 3'd2,
    CAPTURE   = 3'd3,
    DONE_ST   = 3'd4
  } state_t;

`ifdef GATEBIST_SETTLE_EN
  localparam int SETTLE_N = SETTLE;
`else
  // Without the macro the settle hold does not exist; SETTLE folds to zero.
  localparam int SETTLE_N = 0 * SETTLE;
`endif

  localparam logic [IN_W-1:0] SEED_EFF    = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [15:0]     LAST_CNT    = 16'(PATTERNS - 1);
  localparam logic [15:0]     SETTLE_LAST = 16'((SETTLE_N > 0) ? SETTLE_N - 1 : 0);

  state_t            state, state_next;
  logic [IN_W-1:0]   lfsr;
  logic [IN_W-1:0]   lfsr_next;
  logic [15:0]       misr;
  logic [15:0]       misr_next;
  logic [15:0]       cnt;
  logic [15:0]       settle_cnt;
  logic              fb;

  assign fb        = misr[15] ^ misr[13] ^ misr[12] ^ misr[10];
  assign misr_next = {misr[14:0], fb} ^ 16'(resp);
  assign lfsr_next = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[IN_W-3]};
  assign signature = misr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = APPLY;
      end
      APPLY: begin
        busy       = 1'b1;
        state_next = (SETTLE_N > 0) ? SETTLE_ST : CAPTURE;
      end
      SETTLE_ST: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) state_next = CAPTURE;
      end
      CAPTURE: begin
        busy       = 1'b1;
        state_next = (cnt == LAST_CNT) ? DONE_ST : APPLY;
      end
      DONE_ST: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // stim is loaded on the edge entering APPLY so it is valid for the whole vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim       <= '0;
      lfsr       <= '0;
      misr       <= '0;
      cnt        <= '0;
      pass       <= 1'b0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lfsr <= SEED_EFF;
            stim <= SEED_EFF;
            misr <= '0;
            cnt  <= '0;
            pass <= 1'b0;
          end
        end
        APPLY: begin
          settle_cnt <= '0;
        end
        SETTLE_ST: begin
          settle_cnt <= settle_cnt + 16'd1;
        end
        CAPTURE: begin
          misr <= misr_next;
          lfsr <= lfsr_next;
          cnt  <= cnt + 16'd1;
          if (cnt != LAST_CNT) stim <= lfsr_next;
        end
        DONE_ST: begin
          pass <= (misr == GOLDEN);
          stim <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_controller.sv
`default_nettype none
// ============================================================================
// tb_gate_bist_controller: directed self-checking bench for gate_bist_controller.
// Revision: 1.0
// ============================================================================
module tb_gate_bist_controller;

`ifdef GATEBIST_SETTLE_EN
  localparam int CPV = 4;
`else
  localparam int CPV = 2;
`endif
  localparam logic [20:0] SEED_C   = 21'h0ACE1;
  localparam logic [15:0] GOLDEN_C = 16'h1234;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic [20:0] stim_a, stim_b, stim_c, stim_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        done_a, done_b, done_c, done_d;
  logic        pass_a, pass_b, pass_c, pass_d;
  logic [15:0] sig_a, sig_b, sig_c, sig_d;
  logic [9:0]  resp_c;

  // Toy combinational netlist standing in for a GateModel.
  assign resp_c = stim_c[9:0] ^ stim_c[20:11];

  gate_bist_controller #(.IN_W(21), .OUT_W(10), .PATTERNS(4), .SEED(21'h1),
                         .GOLDEN(16'h0000), .SETTLE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .resp(10'h000),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

  gate_bist_controller #(.IN_W(21), .OUT_W(10), .PATTERNS(2), .SEED(21'h1),
                         .GOLDEN(16'h0003), .SETTLE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .resp(10'h001),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

  gate_bist_controller #(.IN_W(21), .OUT_W(10), .PATTERNS(1024), .SEED(SEED_C),
                         .GOLDEN(GOLDEN_C), .SETTLE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .stim(stim_c), .resp(resp_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

  gate_bist_controller #(.IN_W(21), .OUT_W(10), .PATTERNS(1), .SEED(21'h0),
                         .GOLDEN(16'h03FF), .SETTLE(2)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .stim(stim_d), .resp(10'h3FF),
    .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d));

  function automatic logic [15:0] model_sig(input logic [20:0] seed, input int n);
    logic [20:0] l;
    logic [15:0] m;
    logic [9:0]  r;
    logic        f;
    l = (seed == 21'h0) ? 21'h1 : seed;
    m = 16'h0;
    for (int i = 0; i < n; i++) begin
      r = l[9:0] ^ l[20:11];
      f = m[15] ^ m[13] ^ m[12] ^ m[10];
      m = {m[14:0], f} ^ {6'b0, r};
      l = {l[19:0], l[20] ^ l[18]};
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_c(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 1024 * CPV + 50; i++) begin
      if (done_c) begin
        cyc = i;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks += 6;
    if (stim_a !== 21'h0)  begin n_fail++; $display("FAIL reset_stim: got %h want 000000", stim_a); end
    if (sig_a !== 16'h0)   begin n_fail++; $display("FAIL reset_sig: got %h want 0000", sig_a); end
    if (busy_a !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    if (done_a !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    if (pass_a !== 1'b0)   begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass_a); end
    if (stim_c !== 21'h0)  begin n_fail++; $display("FAIL reset_stim_c: got %h want 000000", stim_c); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int done_cyc = -1;
    int busy_cnt = 0;
    int n_done = 0;
    logic [20:0] exp_s;
    @(negedge clk);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (busy_a) busy_cnt++;
      if (done_a) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc <= 4 * CPV) begin
        exp_s = 21'd1 << ((cyc - 1) / CPV);
        n_checks++;
        if (stim_a !== exp_s) begin
          n_fail++;
          $display("FAIL basic_stim cyc %0d: got %h want %h", cyc, stim_a, exp_s);
        end
      end
      step();
    end
    n_checks += 5;
    if (done_cyc != 1 + 4 * CPV) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", done_cyc, 1 + 4 * CPV); end
    if (n_done != 1)             begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", n_done); end
    if (busy_cnt != 4 * CPV)     begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", busy_cnt, 4 * CPV); end
    if (sig_a !== 16'h0000)      begin n_fail++; $display("FAIL basic_sig: got %h want 0000", sig_a); end
    if (pass_a !== 1'b1)         begin n_fail++; $display("FAIL basic_pass: got %b want 1", pass_a); end
  endtask

  task automatic test_two_patterns();
    int done_cyc = -1;
    @(negedge clk);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == CPV + 1) begin
        n_checks++;
        if (sig_b !== 16'h0001) begin n_fail++; $display("FAIL two_sig_first: got %h want 0001", sig_b); end
      end
      if (done_b && done_cyc < 0) begin
        done_cyc = cyc;
        n_checks++;
        if (sig_b !== 16'h0003) begin n_fail++; $display("FAIL two_sig_final: got %h want 0003", sig_b); end
      end
      step();
    end
    n_checks += 2;
    if (done_cyc != 1 + 2 * CPV) begin n_fail++; $display("FAIL two_latency: got %0d want %0d", done_cyc, 1 + 2 * CPV); end
    if (pass_b !== 1'b1)         begin n_fail++; $display("FAIL two_pass: got %b want 1", pass_b); end
  endtask

  task automatic test_single_pattern();
    int done_cyc = -1;
    @(negedge clk);
    start_d = 1'b1;
    step();
    start_d = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 1) begin
        n_checks++;
        if (stim_d !== 21'h1) begin n_fail++; $display("FAIL single_seed0_stim: got %h want 000001", stim_d); end
      end
      if (done_d && done_cyc < 0) done_cyc = cyc;
      step();
    end
    n_checks += 4;
    if (done_cyc != 1 + CPV)  begin n_fail++; $display("FAIL single_latency: got %0d want %0d", done_cyc, 1 + CPV); end
    if (sig_d !== 16'h03FF)   begin n_fail++; $display("FAIL single_sig: got %h want 03ff", sig_d); end
    if (pass_d !== 1'b1)      begin n_fail++; $display("FAIL single_pass: got %b want 1", pass_d); end
    if (stim_d !== 21'h0)     begin n_fail++; $display("FAIL single_stim_idle: got %h want 000000", stim_d); end
  endtask

  task automatic test_model();
    int cyc;
    logic [15:0] exp_sig;
    exp_sig = model_sig(SEED_C, 1024);
    @(negedge clk);
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    wait_done_c(cyc);
    n_checks += 3;
    if (cyc != 1 + 1024 * CPV) begin n_fail++; $display("FAIL model_latency: got %0d want %0d", cyc, 1 + 1024 * CPV); end
    if (sig_c !== exp_sig)     begin n_fail++; $display("FAIL model_sig: got %h want %h", sig_c, exp_sig); end
    step();
    if (pass_c !== (exp_sig == GOLDEN_C)) begin
      n_fail++;
      $display("FAIL model_pass: got %b want %b", pass_c, exp_sig == GOLDEN_C);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int n_done = 0;
    logic [15:0] exp_sig;
    exp_sig = model_sig(SEED_C, 1024);
    @(negedge clk);
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    for (int i = 0; i < 500 * CPV; i++) begin
      if (done_c) n_done++;
      step();
    end
    n_checks++;
    if (busy_c !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b want 1", busy_c); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (stim_c !== 21'h0) begin n_fail++; $display("FAIL midrun_stim: got %h want 000000", stim_c); end
    if (sig_c !== 16'h0)  begin n_fail++; $display("FAIL midrun_sig: got %h want 0000", sig_c); end
    if (busy_c !== 1'b0)  begin n_fail++; $display("FAIL midrun_busy_rst: got %b want 0", busy_c); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done_c) n_done++;
      step();
    end
    n_checks++;
    if (n_done != 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d pulses want 0", n_done); end
    @(negedge clk);
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    wait_done_c(cyc);
    n_checks += 2;
    if (cyc < 0)           begin n_fail++; $display("FAIL midrun_rerun_done: got timeout want done"); end
    if (sig_c !== exp_sig) begin n_fail++; $display("FAIL midrun_rerun_sig: got %h want %h", sig_c, exp_sig); end
    step();
  endtask

  task automatic test_back_to_back();
    int done_cyc = -1;
    int n_done = 0;
    @(negedge clk);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (done_a) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        n_checks += 2;
        if (pass_a !== 1'b1) begin n_fail++; $display("FAIL b2b_pass_held: got %b want 1", pass_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b want 0", busy_a); end
      end
      if (done_cyc > 0 && cyc == done_cyc + 2) begin
        n_checks += 3;
        if (busy_a !== 1'b1)   begin n_fail++; $display("FAIL b2b_restart_busy: got %b want 1", busy_a); end
        if (pass_a !== 1'b0)   begin n_fail++; $display("FAIL b2b_pass_cleared: got %b want 0", pass_a); end
        if (stim_a !== 21'h1)  begin n_fail++; $display("FAIL b2b_restart_stim: got %h want 000001", stim_a); end
      end
      start_a = (cyc == 3) || (cyc >= 6 && !(done_cyc > 0 && cyc >= done_cyc + 2));
      step();
    end
    start_a = 1'b0;
    n_checks += 2;
    if (done_cyc != 1 + 4 * CPV) begin n_fail++; $display("FAIL b2b_ignore_midrun: got %0d want %0d", done_cyc, 1 + 4 * CPV); end
    if (n_done != 2)             begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 2", n_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_patterns();
    test_single_pattern();
    test_model();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
